// File: rtl/io_port_unit_if.sv
// CPU data-memory bus as seen by the I/O responder: the CPU drives address, strobes
// and store data, and the responder returns combinational load data.
interface io_port_unit_if;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] io_read_data;

  modport master (output addr, output we, output re, output wdata, input io_read_data);
  modport slave  (input addr, input we, input re, input wdata, output io_read_data);
endinterface

// File: rtl/io_port_unit.sv
// Memory-mapped I/O responder: four registered output ports, two synchronised input ports
// and a read-clear change-status register. Debounce counters exist only with IO_DEBOUNCE_EN.
module io_port_unit #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IN_WIDTH        = 32
) (
  input  logic                clock,
  input  logic                resetn,
  io_port_unit_if.slave       bus,
  input  logic [IN_WIDTH-1:0] in_port0,
  input  logic [IN_WIDTH-1:0] in_port1,
  output logic [31:0]         out_port0,
  output logic [31:0]         out_port1,
  output logic [31:0]         out_port2,
  output logic [31:0]         out_port3,
  output logic                in_change_irq
);

  localparam logic [4:0] OFF_IN0    = 5'd4;
  localparam logic [4:0] OFF_IN1    = 5'd5;
  localparam logic [4:0] OFF_STATUS = 5'd6;

  logic [4:0]          offset;
  logic                in_window;
  logic                unused_addr_bits;
  logic                status_clear;
  logic [31:0]         out_reg   [4];
  logic [IN_WIDTH-1:0] in_raw    [2];
  logic [IN_WIDTH-1:0] sync_meta [2];
  logic [IN_WIDTH-1:0] sync      [2];
  logic [IN_WIDTH-1:0] db        [2];
  logic [1:0]          db_load;
  logic [1:0]          status;

  assign offset           = bus.addr[6:2];
  assign in_window        = bus.addr[7];
  assign unused_addr_bits = ^{bus.addr[31:8], bus.addr[1:0]};
  assign status_clear     = bus.re & in_window & (offset == OFF_STATUS);

  assign in_raw[0] = in_port0;
  assign in_raw[1] = in_port1;

  assign out_port0 = out_reg[0];
  assign out_port1 = out_reg[1];
  assign out_port2 = out_reg[2];
  assign out_port3 = out_reg[3];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) out_reg[i] <= '0;
    end else if (bus.we && in_window && (offset[4:2] == 3'b000)) begin
      out_reg[offset[1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        sync_meta[i] <= '0;
        sync[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_meta[i] <= in_raw[i];
        sync[i]      <= sync_meta[i];
      end
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam logic [15:0] DB_TARGET = 16'(DEBOUNCE_CYCLES);

  logic [IN_WIDTH-1:0] sync_prev   [2];
  logic [15:0]         db_cnt      [2];
  logic [15:0]         db_cnt_step [2];
  logic [15:0]         db_cnt_next [2];

  // Any movement of the synchronised value restarts the stability count at 1.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_load[i]     = 1'b0;
      db_cnt_next[i] = '0;
      db_cnt_step[i] = (sync[i] != sync_prev[i]) ? 16'd1 : db_cnt[i] + 16'd1;
      if (sync[i] != db[i]) begin
        if (db_cnt_step[i] == DB_TARGET) db_load[i] = 1'b1;
        else                             db_cnt_next[i] = db_cnt_step[i];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        sync_prev[i] <= '0;
        db_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_prev[i] <= sync[i];
        db_cnt[i]    <= db_cnt_next[i];
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_comb begin
    for (int i = 0; i < 2; i++) db_load[i] = (sync[i] != db[i]);
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) db[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (db_load[i]) db[i] <= sync[i];
      end
    end
  end

  // A db update on the same edge as a status read keeps its bit set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status        <= '0;
      in_change_irq <= 1'b0;
    end else begin
      status        <= (status & ~{2{status_clear}}) | db_load;
      in_change_irq <= |status;
    end
  end

  always_comb begin
    bus.io_read_data = '0;
    if (in_window) begin
      case (offset)
        5'd0, 5'd1, 5'd2, 5'd3: bus.io_read_data = out_reg[offset[1:0]];
        OFF_IN0:                bus.io_read_data = 32'(db[0]);
        OFF_IN1:                bus.io_read_data = 32'(db[1]);
        OFF_STATUS:             bus.io_read_data = {30'b0, status};
        default:                bus.io_read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: stimulus queues expected values, a negedge monitor
// compares them. Expectations follow IO_DEBOUNCE_EN when it is defined for the build.
module tb_io_port_unit;

  localparam int DEBOUNCE_CYCLES = 4;
`ifdef IO_DEBOUNCE_EN
  localparam int LATENCY = 2 + DEBOUNCE_CYCLES;
`else
  localparam int LATENCY = 3;
`endif
  localparam int K_READ = 0;
  localparam int K_OUT0 = 1;
  localparam int K_OUT1 = 2;
  localparam int K_OUT2 = 3;
  localparam int K_OUT3 = 4;
  localparam int K_IRQ  = 5;

  logic        clock    = 1'b0;
  logic        resetn   = 1'b0;
  logic [31:0] in_port0 = '0;
  logic [31:0] in_port1 = '0;
  logic [31:0] out_port0, out_port1, out_port2, out_port3;
  logic        in_change_irq;

  string       name_q [$];
  int          kind_q [$];
  logic [31:0] exp_q  [$];
  int          checks   = 0;
  int          failures = 0;

  io_port_unit_if bus ();

  io_port_unit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IN_WIDTH(32)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .bus          (bus),
    .in_port0     (in_port0),
    .in_port1     (in_port1),
    .out_port0    (out_port0),
    .out_port1    (out_port1),
    .out_port2    (out_port2),
    .out_port3    (out_port3),
    .in_change_irq(in_change_irq)
  );

  always #5 clock = ~clock;

  task automatic compare(input string name, input int kind, input logic [31:0] expected);
    logic [31:0] actual;
    case (kind)
      K_READ:  actual = bus.io_read_data;
      K_OUT0:  actual = out_port0;
      K_OUT1:  actual = out_port1;
      K_OUT2:  actual = out_port2;
      K_OUT3:  actual = out_port3;
      K_IRQ:   actual = {31'b0, in_change_irq};
      default: actual = 'x;
    endcase
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: drain every expectation queued during this cycle, mid-cycle.
  always @(negedge clock) begin
    while (exp_q.size() > 0) begin
      compare(name_q.pop_front(), kind_q.pop_front(), exp_q.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic re,
                               input logic [31:0] wdata);
    bus.addr  = addr;
    bus.we    = we;
    bus.re    = re;
    bus.wdata = wdata;
  endtask

  task automatic checkOutput(input string name, input int kind, input logic [31:0] expected);
    name_q.push_back(name);
    kind_q.push_back(kind);
    exp_q.push_back(expected);
  endtask

  task automatic peek(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 1'b0, 1'b0, '0);
    checkOutput(name, K_READ, expected);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(addr, 1'b1, 1'b0, data);
    cycle();
    applyStimulus('0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus('0, 1'b0, 1'b0, '0);
    repeat (3) cycle();
    resetn = 1'b1;

    checkOutput("reset_out0", K_OUT0, 32'h0);
    checkOutput("reset_out1", K_OUT1, 32'h0);
    checkOutput("reset_out2", K_OUT2, 32'h0);
    checkOutput("reset_out3", K_OUT3, 32'h0);
    checkOutput("reset_irq",  K_IRQ,  32'h0);
    peek("reset_in0", 32'h90, 32'h0);
    cycle();
    peek("reset_in1", 32'h94, 32'h0);
    cycle();
    peek("reset_status", 32'h98, 32'h0);
    cycle();

    store(32'h84, 32'hDEAD_BEEF);
    store(32'h80, 32'h1122_3344);
    store(32'h8C, 32'hA5A5_5A5A);
    checkOutput("store_out1", K_OUT1, 32'hDEAD_BEEF);
    checkOutput("store_out2_untouched", K_OUT2, 32'h0);
    peek("load_84", 32'h84, 32'hDEAD_BEEF);
    cycle();
    peek("load_80", 32'h80, 32'h1122_3344);
    cycle();
    peek("load_8c", 32'h8C, 32'hA5A5_5A5A);
    cycle();
    store(32'h90, 32'hFFFF_FFFF);
    peek("ro_write_90", 32'h90, 32'h0);
    cycle();
    store(32'h40, 32'hCAFE_F00D);
    store(32'h04, 32'hCAFE_F00D);
    store(32'hBC, 32'hCAFE_F00D);
    checkOutput("outside_out0", K_OUT0, 32'h1122_3344);
    checkOutput("outside_out1", K_OUT1, 32'hDEAD_BEEF);
    peek("outside_read_04", 32'h04, 32'h0);
    cycle();
    peek("unmapped_read_bc", 32'hBC, 32'h0);
    cycle();

    // Clean step on in_port0; edge e is the e-th rising edge after the change.
    in_port0 = 32'h5;
    for (int e = 1; e <= LATENCY + 1; e++) begin
      cycle();
      if (e == LATENCY - 1) peek("step_in0_before", 32'h90, 32'h0);
      if (e == LATENCY) begin
        peek("step_in0_at", 32'h90, 32'h5);
        checkOutput("step_irq_not_yet", K_IRQ, 32'h0);
      end
      if (e == LATENCY + 1) begin
        peek("step_status", 32'h98, 32'h1);
        checkOutput("step_irq", K_IRQ, 32'h1);
      end
    end
    cycle();

`ifdef IO_DEBOUNCE_EN
    in_port1 = 32'hF;
    repeat (3) cycle();
    in_port1 = 32'h0;
    repeat (8) cycle();
    peek("glitch_in1", 32'h94, 32'h0);
    cycle();
    peek("glitch_status", 32'h98, 32'h1);
    cycle();
`endif

    in_port1 = 32'hA;
    repeat (LATENCY + 2) cycle();
    peek("step_in1", 32'h94, 32'hA);
    cycle();
    peek("both_status", 32'h98, 32'h3);
    cycle();

    applyStimulus(32'h98, 1'b0, 1'b1, '0);
    checkOutput("readclr_first", K_READ, 32'h3);
    cycle();
    applyStimulus(32'h98, 1'b0, 1'b1, '0);
    checkOutput("readclr_second", K_READ, 32'h0);
    checkOutput("readclr_irq_held", K_IRQ, 32'h1);
    cycle();
    peek("readclr_after", 32'h98, 32'h0);
    checkOutput("readclr_irq_drop", K_IRQ, 32'h0);
    cycle();

    // The status read lands on the same edge as in_port1's db update.
    in_port1 = 32'h3;
    for (int e = 1; e <= LATENCY - 1; e++) cycle();
    applyStimulus(32'h98, 1'b0, 1'b1, '0);
    checkOutput("race_read_preclear", K_READ, 32'h0);
    cycle();
    peek("race_status_set", 32'h98, 32'h2);
    cycle();
    peek("race_in1", 32'h94, 32'h3);
    cycle();
    applyStimulus(32'h98, 1'b0, 1'b1, '0);
    checkOutput("race_clear_read", K_READ, 32'h2);
    cycle();
    peek("race_cleared", 32'h98, 32'h0);
    cycle();

    in_port0 = 32'h7;
    repeat (2) cycle();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
    peek("midreset_in0", 32'h90, 32'h0);
    checkOutput("midreset_out1", K_OUT1, 32'h0);
    cycle();
    peek("midreset_status", 32'h98, 32'h0);
    cycle();

    repeat (3) cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
